mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide execution unit. Sits in the EX stage beside the combinational ALU.
- Consumes the md_op control code produced by the ALU decoder stage, plus the rs/rt operand data.
- Owns the architectural HI/LO registers.
- Asserts busy while an operation is in flight, so the hazard unit can stall any later mult/div/mfhi/mflo/mthi/mtlo.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high for mult/multu (legal range >=1).
- DIV_CYCLES, 10, number of cycles busy stays high for div/divu (legal range >=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  qualifies md_op for one cycle; this is the EX-stage instruction-valid signal for md instructions.
- md_op  input  3  operation code; encodings are listed under Behaviour.
- rs_data  input  32  operand A; also the source for mthi/mtlo.
- rt_data  input  32  operand B.
- busy  output  1  high while a mult/div is in progress.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- md_op encodings:
  - 0 NONE
  - 1 MULT
  - 2 MULTU
  - 3 DIV
  - 4 DIVU
  - 5 MTHI
  - 6 MTLO
  - 7 reserved; treated as NONE.
- Reset (reset==0, asynchronous): busy=0, hi=0, lo=0, state=IDLE, counter=0, result temporaries=0.
- State machine has three states: IDLE, MUL, DIV.
- IDLE, rising edge with start=1:
  - MULT/MULTU:
    - Compute the 64-bit product of rs_data and rt_data (signed for MULT, unsigned for MULTU) into temporaries.
    - counter=MULT_CYCLES, busy=1, go to MUL.
  - DIV/DIVU:
    - Compute quotient and remainder into temporaries (signed for DIV, unsigned for DIVU).
    - counter=DIV_CYCLES, busy=1, go to DIV.
  - MTHI: hi<=rs_data. Stay in IDLE, busy stays 0, and the new value is visible the next cycle.
  - MTLO: lo<=rs_data. Same timing as MTHI.
  - NONE or reserved: no effect.
- IDLE with start=0: no change, whatever md_op is.
- MUL/DIV, each rising edge:
  - counter decrements by 1.
  - On the edge where counter goes 1->0: hi<=upper result, lo<=lower result, busy<=0, go to IDLE.
  - Net effect: busy is high for exactly N cycles after the start edge, and the new HI/LO are visible in the same cycle busy first reads 0.
- Result mapping:
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
- Signed divide rules:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0; this case must not trap or go X.
- Divide by zero (rt_data==0, DIV or DIVU):
  - The full DIV_CYCLES busy period still runs.
  - HI and LO are left unchanged at completion.
- Start while busy: the new md_op is ignored entirely, including MTHI/MTLO; the in-flight result is not disturbed. The hazard unit is responsible for never issuing such a start.
- Operand capture: operands are sampled only on the start edge, so later changes to rs_data/rt_data have no effect on the result.
- Reset mid-operation: the operation is aborted immediately. busy=0, hi=lo=0, and no pending write ever occurs.
- hi and lo are driven directly from registers. No combinational path exists from any input to busy, hi or lo.

Decomposition:
- Add these constants to the shared macro.v header:
  - md_op encodings: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - State encodings: MD_IDLE, MD_MUL, MD_DIV.
- The ALU decoder uses the same md_op constants when it generates md_op.
- There is no sub-module. Arithmetic uses behavioural */ and %, and the counter and FSM sit in one module.
- The counter width must cover max(MULT_CYCLES, DIV_CYCLES).

Test Plan:
- MULT, rs=0xFFFFFFFD (-3), rt=5, start for 1 cycle:
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU with the same operands:
  - After 5 cycles, hi=0x00000004, lo=0xFFFFFFF1.
- DIVU, rs=100, rt=7:
  - busy=1 for 10 cycles.
  - Then lo=14, hi=2.
- DIV, rs=0xFFFFFFF9 (-7), rt=2:
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (each visible one cycle later, busy stays 0). Then DIV with rt=0:
  - busy=1 for 10 cycles.
  - hi=0x11 and lo=0x22 are unchanged.
- Start MULTU 2*3, then issue start with MTLO rs=0xAA at cycle 2 of busy, then pull reset low for one cycle in a second MULT at cycle 3:
  - The first operation completes with lo=6, and the MTLO is ignored.
  - During the second operation, reset forces busy=0, hi=lo=0 asynchronously, and no later write occurs.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared md_op encodings, FSM states and sizing helper for the multiply/divide unit.
// The ALU decoder generates md_op from the same md_op_e values.
package mult_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed on the
// start edge, held in temporaries, and committed when the busy counter expires.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

   md_op_e           op;
   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic             div_zero_q, div_zero_d;
   logic             busy_q, busy_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;

   logic [63:0]      mul_a, mul_b, product;
   logic [31:0]      divisor, quot, rem;
   logic             div_ovf;

   assign op = md_op_e'(md_op);

   // Datapath: a zero divisor is replaced by 1 so the divider never goes X;
   // the result is discarded at commit anyway.
   always_comb begin
      mul_a   = (op == MD_MULT) ? {{32{rs_data[31]}}, rs_data} : {32'd0, rs_data};
      mul_b   = (op == MD_MULT) ? {{32{rt_data[31]}}, rt_data} : {32'd0, rt_data};
      product = mul_a * mul_b;
      divisor = (rt_data == 32'd0) ? 32'd1 : rt_data;
      div_ovf = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
      if (op == MD_DIV) begin
         if (div_ovf) begin
            quot = 32'h8000_0000;
            rem  = 32'd0;
         end else begin
            quot = $unsigned($signed(rs_data) / $signed(divisor));
            rem  = $unsigned($signed(rs_data) % $signed(divisor));
         end
      end else begin
         quot = rs_data / divisor;
         rem  = rs_data % divisor;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      res_hi_d   = res_hi_q;
      res_lo_d   = res_lo_q;
      div_zero_d = div_zero_q;
      busy_d     = busy_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  MD_MULT, MD_MULTU: begin
                     res_hi_d = product[63:32];
                     res_lo_d = product[31:0];
                     count_d  = MUL_LOAD;
                     busy_d   = 1'b1;
                     state_d  = ST_MUL;
                  end
                  MD_DIV, MD_DIVU: begin
                     res_hi_d   = rem;
                     res_lo_d   = quot;
                     div_zero_d = (rt_data == 32'd0);
                     count_d    = DIV_LOAD;
                     busy_d     = 1'b1;
                     state_d    = ST_DIV;
                  end
                  MD_MTHI: hi_d = rs_data;
                  MD_MTLO: lo_d = rs_data;
                  default: ;
               endcase
            end
         end
         ST_MUL, ST_DIV: begin
            count_d = count_q - 1'b1;
            if (count_q == CNT_W'(1)) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
               if (!(state_q == ST_DIV && div_zero_q)) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         res_hi_q   <= '0;
         res_lo_q   <= '0;
         div_zero_q <= 1'b0;
         busy_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         res_hi_q   <= res_hi_d;
         res_lo_q   <= res_lo_d;
         div_zero_q <= div_zero_d;
         busy_q     <= busy_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, random ops
// against an arithmetic reference model, and start-while-busy / reset-abort sequences.
module tb_mult_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;
   localparam int BUDGET = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        busy;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one op at 1 time unit after an edge, scrambles operands, and counts busy cycles.
   task automatic apply(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cycles);
      start   = st;
      md_op   = op;
      rs_data = a;
      rt_data = b;
      tick();
      start   = 1'b0;
      md_op   = 3'($urandom_range(0, 7));
      rs_data = $urandom;
      rt_data = $urandom;
      cycles  = 0;
      while (busy === 1'b1 && cycles < BUDGET) begin
         cycles++;
         tick();
      end
   endtask

   // Reference model: plain wide arithmetic on the architectural rules.
   task automatic model(input logic st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
      longint          x, y, q, r;
      longint unsigned p;
      cyc = 0;
      if (!st) return;
      case (op)
         3'd1: begin
            x = longint'($signed(a));
            y = longint'($signed(b));
            p = longint'(x * y);
            m_hi = p[63:32]; m_lo = p[31:0]; cyc = MC;
         end
         3'd2: begin
            p = longint'({32'd0, a}) * longint'({32'd0, b});
            m_hi = p[63:32]; m_lo = p[31:0]; cyc = MC;
         end
         3'd3: begin
            cyc = DC;
            if (b != 0) begin
               x = longint'($signed(a));
               y = longint'($signed(b));
               q = x / y;
               r = x % y;
               m_lo = q[31:0]; m_hi = r[31:0];
            end
         end
         3'd4: begin
            cyc = DC;
            if (b != 0) begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
         3'd5: m_hi = a;
         3'd6: m_lo = a;
         default: ;
      endcase
   endtask

   initial begin
      vec_t vecs[$];
      int   cycles, e_cyc;
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        st;

      vecs.push_back('{1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
      vecs.push_back('{1'b1, 3'd2, 32'hFFFF_FFFD, 32'd5, MC, 32'h0000_0004, 32'hFFFF_FFF1});
      vecs.push_back('{1'b1, 3'd4, 32'd100, 32'd7, DC, 32'd2, 32'd14});
      vecs.push_back('{1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      vecs.push_back('{1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000});
      vecs.push_back('{1'b1, 3'd5, 32'h11, 32'd0, 0, 32'h11, 32'h8000_0000});
      vecs.push_back('{1'b1, 3'd6, 32'h22, 32'd0, 0, 32'h11, 32'h22});
      vecs.push_back('{1'b1, 3'd3, 32'd5, 32'd0, DC, 32'h11, 32'h22});
      vecs.push_back('{1'b1, 3'd4, 32'd5, 32'd0, DC, 32'h11, 32'h22});
      vecs.push_back('{1'b0, 3'd1, 32'd3, 32'd3, 0, 32'h11, 32'h22});
      vecs.push_back('{1'b1, 3'd7, 32'd3, 32'd3, 0, 32'h11, 32'h22});
      vecs.push_back('{1'b1, 3'd3, 32'd7, 32'hFFFF_FFFE, DC, 32'd1, 32'hFFFF_FFFD});

      // Reset state
      #12;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      reset = 1'b1;
      tick();

      foreach (vecs[i]) begin
         apply(vecs[i].st, vecs[i].op, vecs[i].a, vecs[i].b, cycles);
         check($sformatf("vec%0d_cycles", i), 32'(cycles), 32'(vecs[i].cyc));
         check($sformatf("vec%0d_hi", i), hi, vecs[i].e_hi);
         check($sformatf("vec%0d_lo", i), lo, vecs[i].e_lo);
      end

      // Random ops against the model
      m_hi = hi;
      m_lo = lo;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         st = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 5) == 0) b = 32'd0;
         if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
         model(st, op, a, b, e_cyc);
         apply(st, op, a, b, cycles);
         check($sformatf("rnd%0d_op%0d_cycles", i, op), 32'(cycles), 32'(e_cyc));
         check($sformatf("rnd%0d_op%0d_hi", i, op), hi, m_hi);
         check($sformatf("rnd%0d_op%0d_lo", i, op), lo, m_lo);
      end

      // MULTU 2*3 with an MTLO issued on busy cycle 2: the MTLO must be ignored
      start = 1'b1; md_op = 3'd2; rs_data = 32'd2; rt_data = 32'd3;
      tick();
      start = 1'b0; md_op = 3'd0;
      cycles = 1;
      tick();
      cycles++;
      start = 1'b1; md_op = 3'd6; rs_data = 32'hAA;
      tick();
      start = 1'b0; md_op = 3'd0;
      while (busy === 1'b1 && cycles < BUDGET) begin
         cycles++;
         tick();
      end
      check("busy_ign_cycles", 32'(cycles), 32'(MC));
      check("busy_ign_hi", hi, 32'd0);
      check("busy_ign_lo", lo, 32'd6);

      // Second MULT aborted by reset on busy cycle 3
      start = 1'b1; md_op = 3'd1; rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF0;
      tick();
      start = 1'b0; md_op = 3'd0;
      tick();
      tick();
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("abort_busy_async", {31'd0, busy}, 32'd0);
      check("abort_hi_async", hi, 32'd0);
      check("abort_lo_async", lo, 32'd0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < MC + 3; i++) begin
         tick();
         check($sformatf("abort_quiet%0d", i), {busy, hi[30:0] | lo[30:0]}, 32'd0);
         check($sformatf("abort_quiet%0d_top", i), {30'd0, hi[31], lo[31]}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
